// File: rtl/rv32_mod_dmem_responder_if.sv
// ---------------------------------------------------------------------------
// rv32_mod_dmem_responder_if
//
// Load/store external bus between an initiator (the LSU) and the data-memory
// responder. The initiator issues one-cycle request pulses; the responder
// answers each one with a one-cycle ack or err.
//
// Signals:
//   req    initiator -> responder  request pulse, one request per high cycle
//   wr     initiator -> responder  1 = write, 0 = read
//   be     initiator -> responder  byte enables, lane i = bits [8i+7:8i]
//   addr   initiator -> responder  byte address, word aligned
//   wdata  initiator -> responder  lane-positioned write data
//   rdata  responder -> initiator  read data, valid while ack is high
//   ack    responder -> initiator  one-cycle success response
//   err    responder -> initiator  one-cycle error response
//
// Modports: master (initiator side), slave (responder side).
// ---------------------------------------------------------------------------
interface rv32_mod_dmem_responder_if;
    logic        req;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (
        output req,
        output wr,
        output be,
        output addr,
        output wdata,
        input  rdata,
        input  ack,
        input  err
    );

    modport slave (
        input  req,
        input  wr,
        input  be,
        input  addr,
        input  wdata,
        output rdata,
        output ack,
        output err
    );
endinterface

// File: rtl/rv32_mod_dmem_responder.sv
// ---------------------------------------------------------------------------
// rv32_mod_dmem_responder
//
// Single-port data-memory target on the load/store bus. Each request pulse is
// captured, held for WAIT_STATES cycles, then answered with a one-cycle ack
// (byte-enabled write or full-word read) or err (misaligned, empty byte
// enables, or outside the memory window). A one-deep pending slot absorbs a
// request that arrives while the previous one is still in flight; anything
// beyond that is dropped and flagged on the sticky overflow output.
//
// Parameters:
//   DEPTH        memory size in 32-bit words, power of two, at least 2
//   BASE_ADDR    byte address of word 0, aligned to 4*DEPTH
//   WAIT_STATES  extra cycles before the response, 0..15
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   reset     synchronous, active-high
//   bus       load/store bus, slave modport
//   busy      high while a request is in flight or pending
//   overflow  sticky, a request was dropped; cleared only by reset
//
// Build option:
//   RV32_DMEM_RDATA_MASK_EN  when defined, read data lanes with be[i]=0 are
//                            returned as zero; otherwise the whole word is
//                            returned and the initiator picks its lanes.
// ---------------------------------------------------------------------------
module rv32_mod_dmem_responder #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    rv32_mod_dmem_responder_if.slave       bus,
    output logic                           busy,
    output logic                           overflow
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // 33-bit window bounds so a window ending at 2^32 does not wrap.
    localparam logic [32:0] WIN_LO  = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI  = WIN_LO + 33'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state, state_n;
    logic [3:0]  count, count_n;
    req_t        act, act_n;
    req_t        pend, pend_n;
    logic        pend_valid, pend_valid_n;
    logic        overflow_n;
    req_t        new_req;
    req_t        act_src;
    logic        activate;

    logic        access_err;
    logic        ack_n, err_n;
    logic        do_write;
    logic [AW-1:0] idx;
    logic [32:0] addr_ext;
    logic [31:0] rd_word;

    logic        ack_q, err_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [DEPTH];

    assign new_req = {bus.wr, bus.be, bus.addr, bus.wdata};

    // Next-state logic. Request capture and leaving RESP are folded together:
    // in RESP the pending request (if any) always goes first so responses stay
    // in request order, and a simultaneous new request refills the slot.
    always_comb begin
        state_n      = state;
        count_n      = count;
        act_n        = act;
        pend_n       = pend;
        pend_valid_n = pend_valid;
        overflow_n   = overflow;
        activate     = 1'b0;
        act_src      = new_req;

        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (!pend_valid) begin
                        activate = 1'b1;
                        act_src  = new_req;
                    end else begin
                        overflow_n = 1'b1;
                    end
                end
            end

            WAIT: begin
                if (bus.req) begin
                    if (!pend_valid) begin
                        pend_n       = new_req;
                        pend_valid_n = 1'b1;
                    end else begin
                        overflow_n = 1'b1;
                    end
                end
                if (count == 4'd0) begin
                    state_n = RESP;
                end else begin
                    count_n = count - 4'd1;
                end
            end

            RESP: begin
                if (pend_valid) begin
                    activate = 1'b1;
                    act_src  = pend;
                    if (bus.req) begin
                        pend_n = new_req;
                    end else begin
                        pend_valid_n = 1'b0;
                    end
                end else if (bus.req) begin
                    activate = 1'b1;
                    act_src  = new_req;
                end else begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // With no wait states an activated request answers on the very next
        // cycle, so it skips WAIT entirely.
        if (activate) begin
            act_n = act_src;
            if (WAIT_STATES == 0) begin
                state_n = RESP;
            end else begin
                state_n = WAIT;
                count_n = CNT_INIT;
            end
        end
    end

    // Access decode. RESP lasts exactly one cycle, so state_n == RESP always
    // marks the edge that enters RESP; act_n is the request answered there,
    // which may be a request captured on this same edge.
    always_comb begin
        addr_ext   = {1'b0, act_n.addr};
        access_err = (act_n.addr[1:0] != 2'b00) ||
                     (act_n.be == 4'b0000)      ||
                     (addr_ext < WIN_LO)        ||
                     (addr_ext >= WIN_HI);
        idx        = act_n.addr[AW+1:2];
        ack_n      = (state_n == RESP) && !access_err;
        err_n      = (state_n == RESP) && access_err;
        do_write   = ack_n && act_n.wr && !reset;

        rd_word = mem[idx];
`ifdef RV32_DMEM_RDATA_MASK_EN
        for (int i = 0; i < 4; i++) begin
            if (!act_n.be[i]) begin
                rd_word[8*i +: 8] = 8'h00;
            end
        end
`endif
    end

    // Control and response registers. rdata is forced to zero on every
    // cycle that does not carry a read ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            act        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            overflow   <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            act        <= act_n;
            pend       <= pend_n;
            pend_valid <= pend_valid_n;
            overflow   <= overflow_n;
            ack_q      <= ack_n;
            err_q      <= err_n;
            rdata_q    <= (ack_n && !act_n.wr) ? rd_word : 32'h0;
        end
    end

    // Memory array has no reset; do_write already carries the reset veto so
    // an in-flight write is lost when reset lands on its write edge.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (act_n.be[i]) begin
                    mem[idx][8*i +: 8] <= act_n.wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign busy      = (state != IDLE) || pend_valid;

endmodule

// File: tb/tb_rv32_mod_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_rv32_mod_dmem_responder
//
// Three responders side by side (WAIT_STATES = 0, 2, 3) on one clock. Each
// directed request pushes its expected response, including the cycle it must
// appear in, onto a per-instance queue; a negedge monitor pops and compares
// whenever a response shows up.
// ---------------------------------------------------------------------------
module tb_rv32_mod_dmem_responder;

    logic clk;
    logic rst [3];
    logic busy [3];
    logic ovf [3];
    int   cyc;
    int   nvec;
    int   nfail;

    int   wst  [3] = '{0, 2, 3};
    int   last [3] = '{-100, -100, -100};

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t  q0 [$];
    exp_t  q1 [$];
    exp_t  q2 [$];
    string t0 [$];
    string t1 [$];
    string t2 [$];

    rv32_mod_dmem_responder_if bi0 ();
    rv32_mod_dmem_responder_if bi1 ();
    rv32_mod_dmem_responder_if bi2 ();

    rv32_mod_dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset(rst[0]), .bus(bi0), .busy(busy[0]), .overflow(ovf[0]));
    rv32_mod_dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u1 (
        .clk(clk), .reset(rst[1]), .bus(bi1), .busy(busy[1]), .overflow(ovf[1]));
    rv32_mod_dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u2 (
        .clk(clk), .reset(rst[2]), .bus(bi2), .busy(busy[2]), .overflow(ovf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nfail++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic compareResp(input string tag, input logic ack, input logic err,
                               input logic [31:0] rdata, input exp_t e);
        checkOutput({tag, " ack/err"}, {30'd0, ack, err}, {30'd0, e.ack, e.err});
        checkOutput({tag, " rdata"}, rdata, e.rdata);
        checkOutput({tag, " cycle"}, 32'(cyc), 32'(e.cyc));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bi0.req = 1'b0;
            bi1.req = 1'b0;
            bi2.req = 1'b0;
        end
    endtask

    // Drives one request pulse for the next rising edge. Response cycle model:
    // a request is answered WAIT_STATES edges after it is sampled, but never
    // earlier than WAIT_STATES+1 edges after the previous response.
    task automatic applyStimulus(input int d, input logic wr, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic eack, input logic eerr, input logic [31:0] erd,
                                 input logic drop, input string tag);
        exp_t e;
        int   edge_no;
        int   r;
        @(negedge clk);
        bi0.req = 1'b0;
        bi1.req = 1'b0;
        bi2.req = 1'b0;
        case (d)
            0: begin bi0.req = 1'b1; bi0.wr = wr; bi0.be = be; bi0.addr = addr; bi0.wdata = wdata; end
            1: begin bi1.req = 1'b1; bi1.wr = wr; bi1.be = be; bi1.addr = addr; bi1.wdata = wdata; end
            default: begin bi2.req = 1'b1; bi2.wr = wr; bi2.be = be; bi2.addr = addr; bi2.wdata = wdata; end
        endcase
        edge_no = cyc + 1;
        if (!drop) begin
            r = edge_no + wst[d];
            if (last[d] + 1 + wst[d] > r) r = last[d] + 1 + wst[d];
            last[d] = r;
            e.ack   = eack;
            e.err   = eerr;
            e.rdata = erd;
            e.cyc   = r;
            case (d)
                0: begin q0.push_back(e); t0.push_back(tag); end
                1: begin q1.push_back(e); t1.push_back(tag); end
                default: begin q2.push_back(e); t2.push_back(tag); end
            endcase
        end
    endtask

    task automatic checkIdle(input int d, input string tag);
        logic [31:0] rd;
        logic [3:0]  flags;
        case (d)
            0: begin rd = bi0.rdata; flags = {bi0.ack, bi0.err, busy[0], ovf[0]}; end
            1: begin rd = bi1.rdata; flags = {bi1.ack, bi1.err, busy[1], ovf[1]}; end
            default: begin rd = bi2.rdata; flags = {bi2.ack, bi2.err, busy[2], ovf[2]}; end
        endcase
        checkOutput({tag, " ack/err/busy/ovf"}, {28'd0, flags}, 32'd0);
        checkOutput({tag, " rdata"}, rd, 32'd0);
    endtask

    // Response monitor: every response must match the head of its queue;
    // rdata must read zero on every cycle without a response.
    always @(negedge clk) begin
        exp_t  e;
        string tg;
        if (bi0.ack || bi0.err) begin
            if (q0.size() == 0) checkOutput("w0 spurious response", {30'd0, bi0.ack, bi0.err}, 32'd0);
            else begin e = q0.pop_front(); tg = t0.pop_front(); compareResp(tg, bi0.ack, bi0.err, bi0.rdata, e); end
        end else checkOutput("w0 quiet rdata", bi0.rdata, 32'd0);
        if (bi1.ack || bi1.err) begin
            if (q1.size() == 0) checkOutput("w2 spurious response", {30'd0, bi1.ack, bi1.err}, 32'd0);
            else begin e = q1.pop_front(); tg = t1.pop_front(); compareResp(tg, bi1.ack, bi1.err, bi1.rdata, e); end
        end else checkOutput("w2 quiet rdata", bi1.rdata, 32'd0);
        if (bi2.ack || bi2.err) begin
            if (q2.size() == 0) checkOutput("w3 spurious response", {30'd0, bi2.ack, bi2.err}, 32'd0);
            else begin e = q2.pop_front(); tg = t2.pop_front(); compareResp(tg, bi2.ack, bi2.err, bi2.rdata, e); end
        end else checkOutput("w3 quiet rdata", bi2.rdata, 32'd0);
    end

    initial begin
        logic [31:0] lane_exp;
        nvec  = 0;
        nfail = 0;
        bi0.req = 1'b0; bi0.wr = 1'b0; bi0.be = 4'h0; bi0.addr = 32'h0; bi0.wdata = 32'h0;
        bi1.req = 1'b0; bi1.wr = 1'b0; bi1.be = 4'h0; bi1.addr = 32'h0; bi1.wdata = 32'h0;
        bi2.req = 1'b0; bi2.wr = 1'b0; bi2.be = 4'h0; bi2.addr = 32'h0; bi2.wdata = 32'h0;
        rst[0] = 1'b1; rst[1] = 1'b1; rst[2] = 1'b1;

        repeat (3) @(negedge clk);
        checkIdle(0, "reset w0");
        checkIdle(1, "reset w2");
        checkIdle(2, "reset w3");
        rst[0] = 1'b0; rst[1] = 1'b0; rst[2] = 1'b0;
        $display("[TB] reset released at cycle %0d", cyc);

        // ---- WAIT_STATES = 0: basic access, lanes, errors ----
        applyStimulus(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0, "wr 0x10");
        applyStimulus(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, "rd 0x10");
        idle(2);
`ifdef RV32_DMEM_RDATA_MASK_EN
        lane_exp = 32'h00AA0000;
`else
        lane_exp = 32'h11AA3344;
`endif
        applyStimulus(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 1'b1, 1'b0, 32'h0, 1'b0, "wr 0x20 word");
        applyStimulus(0, 1'b1, 4'h4, 32'h20, 32'h00AA0000, 1'b1, 1'b0, 32'h0, 1'b0, "wr 0x20 lane2");
        applyStimulus(0, 1'b0, 4'h4, 32'h20, 32'h0, 1'b1, 1'b0, lane_exp, 1'b0, "rd 0x20 lane2");
        idle(2);
        applyStimulus(0, 1'b0, 4'hF, 32'h22, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, "rd misaligned");
        applyStimulus(0, 1'b0, 4'hF, 32'h1000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, "rd past end");
        applyStimulus(0, 1'b1, 4'hF, 32'hFFC, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h0, 1'b0, "wr last word");
        applyStimulus(0, 1'b0, 4'hF, 32'hFFC, 32'h0, 1'b1, 1'b0, 32'h5A5A5A5A, 1'b0, "rd last word");
        applyStimulus(0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, "wr be=0");
        applyStimulus(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, "rd after be=0");
        idle(2);

        // ---- WAIT_STATES = 0: back-to-back reads ----
        applyStimulus(0, 1'b1, 4'hF, 32'h0, 32'h00000100, 1'b1, 1'b0, 32'h0, 1'b0, "wr 0x0");
        applyStimulus(0, 1'b1, 4'hF, 32'h4, 32'h00000104, 1'b1, 1'b0, 32'h0, 1'b0, "wr 0x4");
        applyStimulus(0, 1'b1, 4'hF, 32'h8, 32'h00000108, 1'b1, 1'b0, 32'h0, 1'b0, "wr 0x8");
        idle(2);
        applyStimulus(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0, 32'h00000100, 1'b0, "b2b rd 0x0");
        applyStimulus(0, 1'b0, 4'hF, 32'h4, 32'h0, 1'b1, 1'b0, 32'h00000104, 1'b0, "b2b rd 0x4");
        checkOutput("b2b busy 1", 32'(busy[0]), 32'd1);
        applyStimulus(0, 1'b0, 4'hF, 32'h8, 32'h0, 1'b1, 1'b0, 32'h00000108, 1'b0, "b2b rd 0x8");
        checkOutput("b2b busy 2", 32'(busy[0]), 32'd1);
        idle(1);
        checkOutput("b2b busy 3", 32'(busy[0]), 32'd1);
        checkOutput("b2b overflow", 32'(ovf[0]), 32'd0);
        idle(1);
        checkOutput("b2b busy drop", 32'(busy[0]), 32'd0);

        // ---- WAIT_STATES = 3: pending slot and overflow ----
        applyStimulus(2, 1'b1, 4'hF, 32'h40, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 1'b0, "w3 wr 0x40");
        applyStimulus(2, 1'b1, 4'hF, 32'h44, 32'h44444444, 1'b1, 1'b0, 32'h0, 1'b0, "w3 wr 0x44 pend");
        checkOutput("w3 busy", 32'(busy[2]), 32'd1);
        checkOutput("w3 ovf before drop", 32'(ovf[2]), 32'd0);
        applyStimulus(2, 1'b1, 4'hF, 32'h40, 32'hBAD0BAD0, 1'b0, 1'b0, 32'h0, 1'b1, "w3 dropped");
        idle(1);
        checkOutput("w3 ovf set", 32'(ovf[2]), 32'd1);
        idle(12);
        checkOutput("w3 ovf held", 32'(ovf[2]), 32'd1);
        checkOutput("w3 idle busy", 32'(busy[2]), 32'd0);
        applyStimulus(2, 1'b0, 4'hF, 32'h40, 32'h0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, "w3 rd 0x40");
        applyStimulus(2, 1'b0, 4'hF, 32'h44, 32'h0, 1'b1, 1'b0, 32'h44444444, 1'b0, "w3 rd 0x44 pend");
        idle(2);
        applyStimulus(2, 1'b0, 4'hF, 32'h40, 32'h0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, "w3 rd in RESP");
        idle(14);

        // ---- WAIT_STATES = 2: reset on the write edge ----
        applyStimulus(1, 1'b1, 4'hF, 32'h30, 32'h12345678, 1'b1, 1'b0, 32'h0, 1'b0, "w2 wr 0x30");
        idle(4);
        applyStimulus(1, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 1'b1, "w2 wr killed");
        idle(2);
        checkOutput("w2 busy in WAIT", 32'(busy[1]), 32'd1);
        rst[1] = 1'b1;
        @(negedge clk);
        checkIdle(1, "w2 mid reset");
        rst[1] = 1'b0;
        last[1] = -100;
        applyStimulus(1, 1'b0, 4'hF, 32'h30, 32'h0, 1'b1, 1'b0, 32'h12345678, 1'b0, "w2 rd 0x30");

        idle(20);
        checkOutput("w0 drained", 32'(q0.size()), 32'd0);
        checkOutput("w2 drained", 32'(q1.size()), 32'd0);
        checkOutput("w3 drained", 32'(q2.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
